// File: rtl/os_pkg.sv
// os_pkg: shared defaults, psum entry layout and writeback FSM states
package os_pkg;
  localparam int ARRAY_ROWS_DEF = 3;
  localparam int PSUM_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [PSUM_W_DEF-1:0] data;
  } psum_entry_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} wb_state_e;
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: synchronous FIFO with combinational head read; a push into a full FIFO not popped this edge is dropped
module psum_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic full, wr_en, rd_en;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    drop = push && !wr_en;
    wr_d = wr_q + {{AW{1'b0}}, wr_en};
    rd_d = rd_q + {{AW{1'b0}}, rd_en};
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/psum_writeback.sv
// psum_writeback: per-row psum FIFOs drained round-robin into a registered memory write; PSUM_WB_RELU_EN clamps negative psums to zero
module psum_writeback
  import os_pkg::*;
#(
  parameter int ARRAY_ROWS = ARRAY_ROWS_DEF,
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [0:ARRAY_ROWS-1]               psum_valid,
  input  logic [0:ARRAY_ROWS-1][ADDR_W-1:0]   psum_addr,
  input  logic [0:ARRAY_ROWS-1][PSUM_W-1:0]   psum_data,
  input  logic                                ctrl_done,
  input  logic                                mem_ready,
  output logic                                out_we,
  output logic [ADDR_W-1:0]                   out_addr,
  output logic [PSUM_W-1:0]                   out_data,
  output logic                                wb_done,
  output logic                                overflow
);
  localparam int EW = ADDR_W + PSUM_W;
  localparam int RW = ARRAY_ROWS > 1 ? $clog2(ARRAY_ROWS) : 1;
  logic [0:ARRAY_ROWS-1] empty, drop, pop;
  logic [EW-1:0] head [ARRAY_ROWS];
  logic [RW-1:0] ptr_q, ptr_d, sel;
  logic found, load, take;
  logic [PSUM_W-1:0] sel_data, wr_data;
  logic out_we_q, out_we_d, overflow_q, overflow_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [PSUM_W-1:0] out_data_q, out_data_d;
  wb_state_e state_q, state_d;
  int k;
  for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
    psum_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (psum_valid[r]),
      .pop   (pop[r]),
      .din   ({psum_addr[r], psum_data[r]}),
      .dout  (head[r]),
      .empty (empty[r]),
      .drop  (drop[r])
    );
  end
  always_comb begin
    found = 1'b0;
    sel = ptr_q;
    k = 0;
    for (int i = 0; i < ARRAY_ROWS; i++) begin
      k = (int'(ptr_q) + i) % ARRAY_ROWS;
      if (!found && !empty[k]) begin
        found = 1'b1;
        sel = RW'(k);
      end
    end
    load = !out_we_q || mem_ready;
    take = load && found;
    for (int r = 0; r < ARRAY_ROWS; r++) pop[r] = take && sel == RW'(r);
    sel_data = head[sel][PSUM_W-1:0];
`ifdef PSUM_WB_RELU_EN
    wr_data = sel_data[PSUM_W-1] ? '0 : sel_data;
`else
    wr_data = sel_data;
`endif
    out_we_d = load ? found : out_we_q;
    out_addr_d = take ? head[sel][EW-1:PSUM_W] : out_addr_q;
    out_data_d = take ? wr_data : out_data_q;
    ptr_d = take ? (sel == RW'(ARRAY_ROWS - 1) ? '0 : sel + 1'b1) : ptr_q;
    overflow_d = overflow_q || |drop;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      out_we_q <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      out_we_q <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = ctrl_done && (state_q == IDLE || state_q == ACTIVE) ? DRAIN
            : state_q == IDLE && |psum_valid ? ACTIVE
            : state_q == DRAIN && &empty && !out_we_q ? DONE
            : state_q == DONE ? IDLE
            : state_q;
  end
  always_comb begin
    wb_done = state_q == DONE;
  end
  assign out_we = out_we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: directed self-checking bench for psum_writeback
module tb_psum_writeback;
  import os_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [0:2] psum_valid;
  logic [0:2][31:0] psum_addr;
  logic [0:2][31:0] psum_data;
  logic ctrl_done, mem_ready;
  logic out_we, wb_done, overflow;
  logic [31:0] out_addr, out_data;
  logic [31:0] neg_exp;
  int passed = 0;
  int total = 0;
  psum_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psum_valid (psum_valid),
    .psum_addr  (psum_addr),
    .psum_data  (psum_data),
    .ctrl_done  (ctrl_done),
    .mem_ready  (mem_ready),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .wb_done    (wb_done),
    .overflow   (overflow)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input int r, input logic [31:0] a, input logic [31:0] d);
    psum_valid[r] = 1'b1;
    psum_addr[r] = a;
    psum_data[r] = d;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask
  initial begin
`ifdef PSUM_WB_RELU_EN
    neg_exp = 32'h0;
`else
    neg_exp = 32'hFFFF_FFFD;
`endif
    rst_n = 1'b0;
    psum_valid = '0;
    psum_addr = '0;
    psum_data = '0;
    ctrl_done = 1'b0;
    mem_ready = 1'b1;
    tick;
    tick;
    chk("rst_we", out_we, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_wb_done", wb_done, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    push(1, 5, 7);
    chk("single_t0_we", out_we, 0);
    tick;
    psum_valid = '0;
    chk("single_t1_we", out_we, 0);
    tick;
    chk("single_t2_we", out_we, 1);
    chk("single_t2_addr", out_addr, 5);
    chk("single_t2_data", out_data, 7);
    tick;
    chk("single_t3_we", out_we, 0);
    do_reset;
    push(0, 20, 10);
    push(1, 21, 11);
    push(2, 22, 12);
    tick;
    psum_valid = '0;
    tick;
    chk("rr_row0_we", out_we, 1);
    chk("rr_row0_addr", out_addr, 20);
    chk("rr_row0_data", out_data, 10);
    tick;
    chk("rr_row1_data", out_data, 11);
    chk("rr_row1_addr", out_addr, 21);
    tick;
    chk("rr_row2_data", out_data, 12);
    chk("rr_row2_addr", out_addr, 22);
    tick;
    chk("rr_idle_we", out_we, 0);
    push(0, 30, 30);
    push(1, 31, 31);
    tick;
    psum_valid = '0;
    tick;
    chk("rr_wrap_row0", out_data, 30);
    tick;
    chk("rr_wrap_row1", out_data, 31);
    tick;
    chk("rr_wrap_idle", out_we, 0);
    push(2, 9, 32'hFFFF_FFFD);
    tick;
    psum_valid = '0;
    tick;
    chk("neg_we", out_we, 1);
    chk("neg_addr", out_addr, 9);
    chk("neg_data", out_data, neg_exp);
    tick;
    push(0, 40, 1);
    ctrl_done = 1'b1;
    chk("done_a0", wb_done, 0);
    tick;
    psum_valid = '0;
    ctrl_done = 1'b0;
    chk("done_a1", wb_done, 0);
    tick;
    chk("done_a2_we", out_we, 1);
    chk("done_a2", wb_done, 0);
    tick;
    chk("done_a3_we", out_we, 0);
    chk("done_a3", wb_done, 0);
    tick;
    chk("done_a4", wb_done, 1);
    tick;
    chk("done_a5", wb_done, 0);
    do_reset;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(0, 50 + i, 40 + i);
      tick;
    end
    chk("ovf_5push_flag", overflow, 0);
    chk("ovf_5push_we", out_we, 1);
    chk("ovf_5push_data", out_data, 40);
    push(0, 55, 45);
    tick;
    psum_valid = '0;
    chk("ovf_6push_flag", overflow, 1);
    chk("ovf_hold_we", out_we, 1);
    chk("ovf_hold_addr", out_addr, 50);
    chk("ovf_hold_data", out_data, 40);
    mem_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick;
      chk("ovf_drain_data", out_data, 64'(40 + i));
    end
    tick;
    chk("ovf_drain_end_we", out_we, 0);
    chk("ovf_sticky", overflow, 1);
    do_reset;
    mem_ready = 1'b0;
    push(0, 60, 60);
    push(1, 61, 61);
    push(2, 62, 62);
    tick;
    psum_valid = '0;
    tick;
    chk("mid_pending_we", out_we, 1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    tick;
    chk("mid_rst_we", out_we, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_state", dut.state_q, IDLE);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mid_after_we", out_we, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
